// File: rtl/matrix_ls_fu.sv
`default_nettype none
// ============================================================================
// Module   : matrix_ls_fu
// Brief    : Matrix load/store functional unit. Computes the effective address
//            and hands one request to the scratchpad, then reports done or a
//            timeout error back to issue.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_ls_fu #(
    parameter int WORD_W      = 32,
    parameter int MREG_W      = 4,
    parameter int IMM_W       = 11,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic              issue_ls,
    input  logic [MREG_W-1:0] issue_rd,
    input  logic [WORD_W-1:0] issue_rs1,
    input  logic [WORD_W-1:0] issue_rs2,
    input  logic [IMM_W-1:0]  issue_imm,
    input  logic              flush,
    output logic              sp_req_valid,
    input  logic              sp_req_ready,
    output logic [1:0]        sp_ls,
    output logic [MREG_W-1:0] sp_rd,
    output logic [IMM_W-1:0]  sp_imm,
    output logic [WORD_W-1:0] sp_addr,
    output logic [WORD_W-1:0] sp_stride,
    input  logic              sp_done,
    output logic              busy,
    output logic              done,
    output logic [MREG_W-1:0] done_rd,
    output logic              err
);

    localparam int              c_cnt_w   = $clog2(TIMEOUT_CYC);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_next;
    logic                r_squash;
    logic                w_squash_next;
    logic                w_accept;
    logic [WORD_W-1:0]   w_addr;

    assign w_accept = issue_valid && (r_state == S_IDLE);
    assign w_addr   = issue_rs1 + {{(WORD_W-IMM_W){issue_imm[IMM_W-1]}}, issue_imm};

    always_comb begin
        w_next        = r_state;
        w_cnt_next    = r_cnt;
        w_squash_next = r_squash;
        case (r_state)
            S_IDLE: begin
                w_cnt_next    = '0;
                w_squash_next = 1'b0;
                if (w_accept)
                    w_next = S_REQ;
            end
            S_REQ: begin
                // A request taken together with flush still has to drain.
                if (sp_req_ready) begin
                    w_cnt_next    = '0;
                    w_squash_next = flush;
                    if (sp_done)
                        w_next = flush ? S_IDLE : S_DONE;
                    else
                        w_next = S_WAIT;
                end else if (flush) begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT: begin
                w_squash_next = r_squash | flush;
                if (sp_done)
                    w_next = (r_squash | flush) ? S_IDLE : S_DONE;
                else if (r_cnt == c_cnt_max)
                    w_next = S_ERR;
                else
                    w_cnt_next = r_cnt + c_cnt_w'(1);
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_squash     <= 1'b0;
            issue_ready  <= 1'b1;
            sp_req_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            done_rd      <= '0;
            sp_ls        <= '0;
            sp_rd        <= '0;
            sp_imm       <= '0;
            sp_addr      <= '0;
            sp_stride    <= '0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt_next;
            r_squash     <= w_squash_next;
            // Status outputs are registered from the next state.
            issue_ready  <= (w_next == S_IDLE);
            sp_req_valid <= (w_next == S_REQ);
            busy         <= (w_next != S_IDLE);
            done         <= (w_next == S_DONE);
            err          <= (w_next == S_ERR);
            done_rd      <= ((w_next == S_DONE) || (w_next == S_ERR)) ? sp_rd : '0;
            if (w_accept) begin
                sp_ls     <= {issue_ls, ~issue_ls};
                sp_rd     <= issue_rd;
                sp_imm    <= issue_imm;
                sp_addr   <= w_addr;
                sp_stride <= issue_rs2;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_ls_fu.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_ls_fu
// Brief    : Directed bench for matrix_ls_fu with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_ls_fu;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 0, issue_ls = 0, flush = 0;
    logic [3:0]  issue_rd = 0;
    logic [31:0] issue_rs1 = 0, issue_rs2 = 0;
    logic [10:0] issue_imm = 0;
    logic        sp_req_ready = 0, sp_done = 0;
    logic        issue_ready, sp_req_valid, busy, done, err;
    logic [1:0]  sp_ls;
    logic [3:0]  sp_rd, done_rd;
    logic [10:0] sp_imm;
    logic [31:0] sp_addr, sp_stride;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    bit started = 0;

    always #5 clk = ~clk;

    matrix_ls_fu #(.WORD_W(32), .MREG_W(4), .IMM_W(11), .TIMEOUT_CYC(TMO)) dut (
        .CLK(clk), .RST(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_ls(issue_ls),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_imm(issue_imm), .flush(flush),
        .sp_req_valid(sp_req_valid), .sp_req_ready(sp_req_ready), .sp_ls(sp_ls),
        .sp_rd(sp_rd), .sp_imm(sp_imm), .sp_addr(sp_addr), .sp_stride(sp_stride),
        .sp_done(sp_done), .busy(busy), .done(done), .done_rd(done_rd), .err(err)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase of the op plus the payload captured at accept.
    localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_DONE = 3, P_ERR = 4;
    int          m_phase = P_IDLE;
    int          m_waited = 0;
    bit          m_squash = 0;
    logic [1:0]  m_ls;
    logic [3:0]  m_rd;
    logic [10:0] m_imm;
    logic [31:0] m_addr, m_stride;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = P_IDLE; m_waited = 0; m_squash = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (issue_valid) begin
                    m_ls     = issue_ls ? 2'b10 : 2'b01;
                    m_rd     = issue_rd;
                    m_imm    = issue_imm;
                    m_addr   = issue_rs1 + 32'($signed(issue_imm));
                    m_stride = issue_rs2;
                    m_phase  = P_REQ;
                end
                P_REQ: if (sp_req_ready) begin
                    m_squash = flush;
                    m_waited = 0;
                    m_phase  = sp_done ? (flush ? P_IDLE : P_DONE) : P_WAIT;
                end else if (flush) m_phase = P_IDLE;
                P_WAIT: begin
                    if (flush) m_squash = 1;
                    if (sp_done) m_phase = m_squash ? P_IDLE : P_DONE;
                    else begin
                        m_waited++;
                        if (m_waited == TMO) m_phase = P_ERR;
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    always @(negedge clk) if (started) begin
        cmp("issue_ready", 32'(issue_ready), 32'(m_phase == P_IDLE));
        cmp("sp_req_valid", 32'(sp_req_valid), 32'(m_phase == P_REQ));
        cmp("busy", 32'(busy), 32'(m_phase != P_IDLE));
        cmp("done", 32'(done), 32'(m_phase == P_DONE));
        cmp("err", 32'(err), 32'(m_phase == P_ERR));
        if (m_phase == P_DONE || m_phase == P_ERR) cmp("done_rd", 32'(done_rd), 32'(m_rd));
        if (m_phase == P_REQ) begin
            cmp("sp_ls", 32'(sp_ls), 32'(m_ls));
            cmp("sp_rd", 32'(sp_rd), 32'(m_rd));
            cmp("sp_imm", 32'(sp_imm), 32'(m_imm));
            cmp("sp_addr", sp_addr, m_addr);
            cmp("sp_stride", sp_stride, m_stride);
        end
    end

    always @(posedge clk) begin
        #1;
        if (done === 1'b1) n_done++;
    end

    task automatic accept(input logic ls, input logic [3:0] rd, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [10:0] imm);
        @(negedge clk);
        issue_valid = 1; issue_ls = ls; issue_rd = rd;
        issue_rs1 = rs1; issue_rs2 = rs2; issue_imm = imm;
        @(negedge clk);
        issue_valid = 0;
    endtask

    int d0;

    initial begin
        @(posedge clk);
        started = 1;
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        cmp("lit_rst_ready", 32'(issue_ready), 32'd1);
        cmp("lit_rst_busy", 32'(busy), 32'd0);

        // Load, immediate ready, completion one cycle later
        accept(1'b1, 4'd5, 32'h1000, 32'h40, 11'h010);
        cmp("lit_ld_valid", 32'(sp_req_valid), 32'd1);
        cmp("lit_ld_addr", sp_addr, 32'h0000_1010);
        cmp("lit_ld_ls", 32'(sp_ls), 32'h2);
        cmp("lit_ld_stride", sp_stride, 32'h40);
        sp_req_ready = 1;
        @(negedge clk);
        sp_req_ready = 0; sp_done = 1;
        cmp("lit_ld_wait_valid", 32'(sp_req_valid), 32'd0);
        @(negedge clk);
        sp_done = 0;
        cmp("lit_ld_done", 32'(done), 32'd1);
        cmp("lit_ld_done_rd", 32'(done_rd), 32'd5);
        @(negedge clk);
        cmp("lit_ld_ready_again", 32'(issue_ready), 32'd1);
        cmp("lit_ld_busy_clear", 32'(busy), 32'd0);

        // Store, negative immediate, three cycles of backpressure
        d0 = n_done;
        accept(1'b0, 4'd3, 32'h2000, 32'h80, 11'h7F8);
        for (int i = 0; i < 3; i++) begin
            cmp("lit_st_valid", 32'(sp_req_valid), 32'd1);
            cmp("lit_st_addr", sp_addr, 32'h0000_1FF8);
            cmp("lit_st_ls", 32'(sp_ls), 32'h1);
            @(negedge clk);
        end
        cmp("lit_st_addr_last", sp_addr, 32'h0000_1FF8);
        sp_req_ready = 1;
        @(negedge clk);
        sp_req_ready = 0; sp_done = 1;
        @(negedge clk);
        sp_done = 0;
        cmp("lit_st_done_rd", 32'(done_rd), 32'd3);
        repeat (2) @(negedge clk);
        cmp("lit_st_single_done", 32'(n_done - d0), 32'd1);

        // Address wrap; ready and completion in the same cycle
        accept(1'b1, 4'd7, 32'hFFFF_FFFC, 32'h4, 11'd8);
        cmp("lit_wrap_addr", sp_addr, 32'h0000_0004);
        sp_req_ready = 1; sp_done = 1;
        @(negedge clk);
        sp_req_ready = 0; sp_done = 0;
        cmp("lit_wrap_done", 32'(done), 32'd1);
        cmp("lit_wrap_err", 32'(err), 32'd0);
        @(negedge clk);

        // Flush while idle has no effect
        flush = 1;
        @(negedge clk);
        flush = 0;
        cmp("lit_idle_flush_ready", 32'(issue_ready), 32'd1);

        // Flush in REQ withdraws the request
        d0 = n_done;
        accept(1'b1, 4'd2, 32'h3000, 32'h8, 11'h0);
        flush = 1;
        @(negedge clk);
        flush = 0;
        cmp("lit_fl_req_ready", 32'(issue_ready), 32'd1);
        cmp("lit_fl_req_valid", 32'(sp_req_valid), 32'd0);
        repeat (2) @(negedge clk);
        cmp("lit_fl_req_no_done", 32'(n_done - d0), 32'd0);

        // Flush in WAIT, later completion is swallowed
        d0 = n_done;
        accept(1'b0, 4'd4, 32'h4000, 32'h10, 11'h004);
        sp_req_ready = 1;
        @(negedge clk);
        sp_req_ready = 0; flush = 1;
        @(negedge clk);
        flush = 0; sp_done = 1;
        @(negedge clk);
        sp_done = 0;
        cmp("lit_fl_wait_ready", 32'(issue_ready), 32'd1);
        @(negedge clk);
        cmp("lit_fl_wait_no_done", 32'(n_done - d0), 32'd0);

        // Timeout: no completion for TMO wait cycles
        d0 = n_done;
        accept(1'b1, 4'd9, 32'h5000, 32'h20, 11'h001);
        sp_req_ready = 1;
        @(negedge clk);
        sp_req_ready = 0;
        for (int i = 0; i < TMO; i++) begin
            cmp("lit_tmo_err_low", 32'(err), 32'd0);
            @(negedge clk);
        end
        cmp("lit_tmo_err", 32'(err), 32'd1);
        cmp("lit_tmo_done_rd", 32'(done_rd), 32'd9);
        cmp("lit_tmo_done_low", 32'(done), 32'd0);
        @(negedge clk);
        cmp("lit_tmo_idle", 32'(issue_ready), 32'd1);
        cmp("lit_tmo_no_done", 32'(n_done - d0), 32'd0);

        // Reset asserted for two cycles from mid-WAIT
        accept(1'b1, 4'd6, 32'h6000, 32'h20, 11'h002);
        sp_req_ready = 1;
        @(negedge clk);
        sp_req_ready = 0;
        @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        cmp("lit_mrst_ready", 32'(issue_ready), 32'd1);
        cmp("lit_mrst_valid", 32'(sp_req_valid), 32'd0);
        cmp("lit_mrst_busy", 32'(busy), 32'd0);
        cmp("lit_mrst_done", 32'(done), 32'd0);
        cmp("lit_mrst_err", 32'(err), 32'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
